sort_order_checker: RTL and testbench
=====================================

# sort_order_checker

Stream monitor that sits directly downstream of `main_sort` and consumes its sorted Avalon-ST packet output. It forwards every beat through a single registered pipeline stage. It also checks each packet for non-decreasing order, legal framing and length within MAX_PKT_LEN, and reports per-packet status plus sticky error flags and counters. It is used on hardware and in simulation to qualify the sorter without a scoreboard.

## Interface
- DWIDTH, 32, data word width; words are compared as unsigned.
- MAX_PKT_LEN, 128, maximum legal packet length in beats (≥2).
- clk_i  in  1  single clock; all logic on rising edge.
- srst_i  in  1  synchronous, active-high reset.
- snk_data_i  in  DWIDTH  input word (from sorter).
- snk_startofpacket_i  in  1  first beat of a packet.
- snk_endofpacket_i  in  1  last beat of a packet.
- snk_valid_i  in  1  input beat valid.
- snk_ready_o  out  1  block can accept a beat.
- src_data_o  out  DWIDTH  forwarded word.
- src_startofpacket_o  out  1  forwarded SOP.
- src_endofpacket_o  out  1  forwarded EOP.
- src_valid_o  out  1  output beat valid.
- src_ready_i  in  1  downstream ready.
- clr_i  in  1  clears sticky flags and both counters.
- pkt_done_o  out  1  one-cycle pulse: a packet has closed.
- pkt_err_o  out  1  qualifies pkt_done_o: the closed packet had an error.
- err_flags_o  out  4  sticky: [0] order, [1] orphan beat, [2] duplicate SOP, [3] over-length.
- pkt_cnt_o  out  32  packets closed; wraps.
- err_cnt_o  out  16  packets closed with error; saturates at 16'hFFFF.

## Operation
- Input handshake: beat accepted when snk_valid_i && snk_ready_o. Output transfer: src_valid_o && src_ready_i.
- Pipeline register loads on accept. snk_ready_o = !srst_i && (!src_valid_o || src_ready_i). src_valid_o clears on transfer with no new accept.
- Data, SOP and EOP are forwarded unmodified. The checker never drops, alters or stalls beats.
- FSM states:
  - IDLE (outside packet). SOP beat → IN_PKT; SOP+EOP beat closes a 1-beat packet and stays IDLE. Non-SOP beat sets orphan flag, stays IDLE, does not count as a packet, and produces no pkt_done_o.
  - IN_PKT. EOP beat closes the packet → IDLE. SOP beat (with or without EOP) sets dup-SOP, closes the current packet as errored, and starts a new packet with this beat (→ IDLE if it also has EOP).
- Per-packet registers:
  - prev word.
  - len counter, $clog2(MAX_PKT_LEN+2) bits, saturating at MAX_PKT_LEN+1.
  - err accumulator.
- Order check: a non-SOP beat in IN_PKT with data < prev sets order. Equal values are legal.
- Length check: the beat that makes len = MAX_PKT_LEN+1 sets over-length. This fires once per packet.
- A packet's error = any check fired on any of its beats, including the closing beat.
- On packet close, pkt_cnt_o increments. err_cnt_o increments if the packet errored.
- If the dup-SOP packet itself closes errored in the same beat (SOP+EOP), only one close is counted for the old packet. The new 1-beat packet is counted the next cycle as a second pkt_done_o pulse, held in a 1-deep pending flag.
- Sticky flags OR-in newly detected errors each cycle.
- clr_i zeroes flags and counters. A set or increment in the same cycle as clr_i wins, giving a result of 1 or 0+1.
- clr_i does not affect FSM, pipeline or per-packet state.

## Timing
- Data latency: 1 cycle (accept at edge N → src_* valid after edge N).
- pkt_done_o, pkt_err_o, flags and counters update on the edge following the closing/offending accept. They are registered outputs with no combinational input paths.
- Reset: src_valid_o, src_startofpacket_o, src_endofpacket_o, pkt_done_o, pkt_err_o = 0; src_data_o = 0; err_flags_o = 0; pkt_cnt_o = 0; err_cnt_o = 0; FSM = IDLE; snk_ready_o = 0 while srst_i is high.
- Reset mid-packet discards the open packet with no pulse. The first post-reset non-SOP beat counts as orphan.
- Backpressure: with src_ready_i low and src_valid_o high, snk_ready_o = 0. No beat is lost or duplicated.

## Test plan
- Packet [1,2,2,9] with continuous ready → identical output 1 cycle later; one pkt_done_o with pkt_err_o=0; pkt_cnt_o=1; flags=0.
- Packet [5,3,7] → pkt_err_o=1; err_flags_o=4'b0001; err_cnt_o=1.
- Beat without SOP while idle, then packet [4] with SOP+EOP → err_flags_o[1]=1; pkt_cnt_o=1; err_cnt_o=0.
- Packet [1,2] without EOP, then packet [3,4] → first pkt_done_o has pkt_err_o=1 with flag[2] set; second pkt_done_o has pkt_err_o=0; pkt_cnt_o=2.
- Ascending packet of MAX_PKT_LEN+1 beats → flag[3] set on the last beat; one errored close. A packet of exactly MAX_PKT_LEN beats is clean.
- Random src_ready_i toggling on a 50-beat packet → output sequence identical to input. Assert clr_i mid-run → flags and counters return to 0.

Source files
------------

// File: rtl/sort_order_checker_if.sv
// Stream and status bundle for sort_order_checker; slave is the checker side,
// master is the upstream/downstream/host side.
interface sort_order_checker_if #(
  parameter int DWIDTH = 32
);
  logic [DWIDTH-1:0] snk_data_i;
  logic              snk_startofpacket_i;
  logic              snk_endofpacket_i;
  logic              snk_valid_i;
  logic              snk_ready_o;

  logic [DWIDTH-1:0] src_data_o;
  logic              src_startofpacket_o;
  logic              src_endofpacket_o;
  logic              src_valid_o;
  logic              src_ready_i;

  logic              clr_i;
  logic              pkt_done_o;
  logic              pkt_err_o;
  logic [3:0]        err_flags_o;
  logic [31:0]       pkt_cnt_o;
  logic [15:0]       err_cnt_o;

  modport slave (
    input  snk_data_i, snk_startofpacket_i, snk_endofpacket_i, snk_valid_i,
    output snk_ready_o,
    output src_data_o, src_startofpacket_o, src_endofpacket_o, src_valid_o,
    input  src_ready_i,
    input  clr_i,
    output pkt_done_o, pkt_err_o, err_flags_o, pkt_cnt_o, err_cnt_o
  );

  modport master (
    output snk_data_i, snk_startofpacket_i, snk_endofpacket_i, snk_valid_i,
    input  snk_ready_o,
    input  src_data_o, src_startofpacket_o, src_endofpacket_o, src_valid_o,
    output src_ready_i,
    output clr_i,
    input  pkt_done_o, pkt_err_o, err_flags_o, pkt_cnt_o, err_cnt_o
  );
endinterface

// File: rtl/sort_order_checker.sv
// Sorted-stream monitor: forwards beats through one register stage (1-cycle latency) and checks order/framing/length.
// Backpressure passes straight through: snk_ready_o follows the output register's ability to drain; beats are never dropped.
module sort_order_checker #(
  parameter int DWIDTH      = 32,
  parameter int MAX_PKT_LEN = 128
) (
  input  logic                 clk_i,
  input  logic                 srst_i,
  sort_order_checker_if.slave  bus
);

  localparam int LW = $clog2(MAX_PKT_LEN + 2);
  localparam logic [LW-1:0] LEN_MAX = LW'(MAX_PKT_LEN);
  localparam logic [LW-1:0] LEN_SAT = LW'(MAX_PKT_LEN + 1);

  typedef enum logic {
    IDLE,
    IN_PKT
  } state_t;

  state_t            state_q, state_d;

  logic [DWIDTH-1:0] src_data_q, src_data_d;
  logic              src_sop_q, src_sop_d;
  logic              src_eop_q, src_eop_d;
  logic              src_vld_q, src_vld_d;

  logic [DWIDTH-1:0] prev_q, prev_d;
  logic [LW-1:0]     len_q, len_d;
  logic              perr_q, perr_d;
  logic              pend_q, pend_d;

  logic              done_q, done_d;
  logic              derr_q, derr_d;
  logic [3:0]        flags_q, flags_d;
  logic [31:0]       pkt_cnt_q, pkt_cnt_d;
  logic [15:0]       err_cnt_q, err_cnt_d;

  logic              snk_rdy;
  logic              accept;
  logic [3:0]        new_err;
  logic              close_now;
  logic              close_err;
  logic              pend_set;
  logic              order_err;
  logic              over_err;
  logic              beat_err;
  logic [31:0]       pkt_base;
  logic [15:0]       err_base;

  always_comb begin
    snk_rdy = !srst_i && (!src_vld_q || bus.src_ready_i);
    accept  = bus.snk_valid_i && snk_rdy;

    src_data_d = src_data_q;
    src_sop_d  = src_sop_q;
    src_eop_d  = src_eop_q;
    src_vld_d  = src_vld_q;
    if (accept) begin
      src_data_d = bus.snk_data_i;
      src_sop_d  = bus.snk_startofpacket_i;
      src_eop_d  = bus.snk_endofpacket_i;
      src_vld_d  = 1'b1;
    end else if (bus.src_ready_i) begin
      src_vld_d  = 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    len_d     = len_q;
    perr_d    = perr_q;
    new_err   = 4'b0000;
    close_now = 1'b0;
    close_err = 1'b0;
    pend_set  = 1'b0;
    order_err = 1'b0;
    over_err  = 1'b0;
    beat_err  = 1'b0;

    if (accept) begin
      case (state_q)
        IDLE: begin
          if (bus.snk_startofpacket_i) begin
            prev_d = bus.snk_data_i;
            len_d  = LW'(1);
            perr_d = 1'b0;
            if (bus.snk_endofpacket_i) begin
              close_now = 1'b1;
            end else begin
              state_d = IN_PKT;
            end
          end else begin
            new_err[1] = 1'b1;
          end
        end

        IN_PKT: begin
          if (bus.snk_startofpacket_i) begin
            // The SOP beat closes the old packet and opens a fresh, clean one.
            new_err[2] = 1'b1;
            close_now  = 1'b1;
            close_err  = 1'b1;
            prev_d     = bus.snk_data_i;
            len_d      = LW'(1);
            perr_d     = 1'b0;
            if (bus.snk_endofpacket_i) begin
              pend_set = 1'b1;
              state_d  = IDLE;
            end
          end else begin
            order_err  = (bus.snk_data_i < prev_q);
            over_err   = (len_q == LEN_MAX);
            beat_err   = perr_q || order_err || over_err;
            new_err[0] = order_err;
            new_err[3] = over_err;
            len_d      = (len_q == LEN_SAT) ? len_q : len_q + LW'(1);
            prev_d     = bus.snk_data_i;
            perr_d     = beat_err;
            if (bus.snk_endofpacket_i) begin
              close_now = 1'b1;
              close_err = beat_err;
              state_d   = IDLE;
            end
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    done_d = 1'b0;
    derr_d = 1'b0;
    pend_d = pend_q;
    // A deferred close only drains in a cycle with no close of its own.
    if (close_now) begin
      done_d = 1'b1;
      derr_d = close_err;
      pend_d = pend_q || pend_set;
    end else if (pend_q) begin
      done_d = 1'b1;
      derr_d = 1'b0;
      pend_d = 1'b0;
    end

    flags_d   = (bus.clr_i ? 4'b0000 : flags_q) | new_err;

    pkt_base  = bus.clr_i ? 32'd0 : pkt_cnt_q;
    pkt_cnt_d = pkt_base + {31'd0, done_d};

    err_base  = bus.clr_i ? 16'd0 : err_cnt_q;
    err_cnt_d = err_base;
    if (done_d && derr_d && (err_base != 16'hFFFF)) begin
      err_cnt_d = err_base + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q    <= IDLE;
      src_data_q <= '0;
      src_sop_q  <= 1'b0;
      src_eop_q  <= 1'b0;
      src_vld_q  <= 1'b0;
      prev_q     <= '0;
      len_q      <= '0;
      perr_q     <= 1'b0;
      pend_q     <= 1'b0;
      done_q     <= 1'b0;
      derr_q     <= 1'b0;
      flags_q    <= 4'b0000;
      pkt_cnt_q  <= 32'd0;
      err_cnt_q  <= 16'd0;
    end else begin
      state_q    <= state_d;
      src_data_q <= src_data_d;
      src_sop_q  <= src_sop_d;
      src_eop_q  <= src_eop_d;
      src_vld_q  <= src_vld_d;
      prev_q     <= prev_d;
      len_q      <= len_d;
      perr_q     <= perr_d;
      pend_q     <= pend_d;
      done_q     <= done_d;
      derr_q     <= derr_d;
      flags_q    <= flags_d;
      pkt_cnt_q  <= pkt_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign bus.snk_ready_o         = snk_rdy;
  assign bus.src_data_o          = src_data_q;
  assign bus.src_startofpacket_o = src_sop_q;
  assign bus.src_endofpacket_o   = src_eop_q;
  assign bus.src_valid_o         = src_vld_q;
  assign bus.pkt_done_o          = done_q;
  assign bus.pkt_err_o           = derr_q;
  assign bus.err_flags_o         = flags_q;
  assign bus.pkt_cnt_o           = pkt_cnt_q;
  assign bus.err_cnt_o           = err_cnt_q;

endmodule

// File: tb/tb_sort_order_checker.sv
// Randomised bench for sort_order_checker against a packet-level reference model.
module tb_sort_order_checker;
  localparam int DW        = 32;
  localparam int MAXL      = 128;
  localparam int RUN_LIMIT = 20000;

  typedef struct packed {
    logic          sop;
    logic          eop;
    logic [DW-1:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic srst;
  always #5 clk = ~clk;

  sort_order_checker_if #(.DWIDTH(DW)) bus ();

  sort_order_checker #(.DWIDTH(DW), .MAX_PKT_LEN(MAXL)) dut (
    .clk_i  (clk),
    .srst_i (srst),
    .bus    (bus.slave)
  );

  int n_chk = 0;
  int n_err = 0;

  beat_t stim[$];
  beat_t outq[$];
  bit    evq[$];

  // Reference model: packet-level view of the stream.
  bit          m_in_pkt;
  int          m_len;
  logic [31:0] m_last;
  bit          m_perr;
  logic [3:0]  m_flags;
  logic [31:0] m_pkt;
  int          m_errc;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic void m_close(bit e);
    evq.push_back(e);
    m_pkt++;
    if (e && m_errc < 65535) m_errc++;
  endfunction

  function automatic void m_start(beat_t b);
    m_in_pkt = 1'b1;
    m_len    = 1;
    m_last   = b.data;
    m_perr   = 1'b0;
  endfunction

  function automatic void m_beat(beat_t b);
    if (!m_in_pkt) begin
      if (!b.sop) m_flags[1] = 1'b1;
      else begin
        m_start(b);
        if (b.eop) begin m_close(1'b0); m_in_pkt = 1'b0; end
      end
    end else if (b.sop) begin
      m_flags[2] = 1'b1;
      m_close(1'b1);
      m_start(b);
      if (b.eop) begin m_close(1'b0); m_in_pkt = 1'b0; end
    end else begin
      m_len++;
      if (b.data < m_last) begin m_flags[0] = 1'b1; m_perr = 1'b1; end
      if (m_len == MAXL + 1) begin m_flags[3] = 1'b1; m_perr = 1'b1; end
      m_last = b.data;
      if (b.eop) begin m_close(m_perr); m_in_pkt = 1'b0; end
    end
  endfunction

  function automatic void m_reset();
    m_in_pkt = 1'b0; m_len = 0; m_last = '0; m_perr = 1'b0;
    m_flags = 4'b0; m_pkt = 32'd0; m_errc = 0;
    evq.delete(); outq.delete();
  endfunction

  function automatic void push(logic [31:0] d, bit s, bit e);
    beat_t b;
    b.sop = s; b.eop = e; b.data = d;
    stim.push_back(b);
  endfunction

  task automatic run(input bit vrand, input bit rrand, input int clr_idx);
    int idx = 0;
    int cyc = 0;
    int drain = 0;
    bit acc = 1'b0;
    bit acc_prev = 1'b0;
    beat_t e;
    while ((stim.size() > 0 || outq.size() > 0 || drain < 4) && cyc < RUN_LIMIT) begin
      @(posedge clk); #1;
      if (stim.size() > 0) begin
        bus.snk_valid_i         = vrand ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.snk_data_i          = stim[0].data;
        bus.snk_startofpacket_i = stim[0].sop;
        bus.snk_endofpacket_i   = stim[0].eop;
      end else begin
        bus.snk_valid_i         = 1'b0;
        bus.snk_data_i          = '0;
        bus.snk_startofpacket_i = 1'b0;
        bus.snk_endofpacket_i   = 1'b0;
      end
      bus.src_ready_i = rrand ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.clr_i       = (idx == clr_idx) && bus.snk_valid_i;
      @(negedge clk);
      if (!rrand && acc_prev) check("latency_vld", bus.src_valid_o, 1);
      if (bus.src_valid_o && bus.src_ready_i) begin
        if (outq.size() == 0) check("extra_beat", bus.src_valid_o, 0);
        else begin
          e = outq.pop_front();
          check("out_data", bus.src_data_o, e.data);
          check("out_sop_eop", {bus.src_startofpacket_o, bus.src_endofpacket_o}, {e.sop, e.eop});
        end
      end
      if (bus.pkt_done_o) begin
        if (evq.size() == 0) check("spurious_done", bus.pkt_done_o, 0);
        else check("done_err", bus.pkt_err_o, evq.pop_front());
      end
      if (bus.clr_i) begin m_flags = 4'b0; m_pkt = 32'd0; m_errc = 0; end
      acc = bus.snk_valid_i && bus.snk_ready_o;
      if (acc) begin
        m_beat(stim[0]);
        outq.push_back(stim[0]);
        void'(stim.pop_front());
        idx++;
      end
      acc_prev = acc;
      if (stim.size() == 0 && outq.size() == 0) drain++;
      cyc++;
    end
    bus.snk_valid_i = 1'b0;
    bus.clr_i       = 1'b0;
    bus.src_ready_i = 1'b1;
    check("run_in_budget", 32'(cyc < RUN_LIMIT), 1);
    check("missed_done", evq.size(), 0);
    stim.delete();
  endtask

  task automatic check_status(input string tag);
    @(negedge clk);
    check({tag, "_flags"}, bus.err_flags_o, m_flags);
    check({tag, "_pkt_cnt"}, bus.pkt_cnt_o, m_pkt);
    check({tag, "_err_cnt"}, bus.err_cnt_o, m_errc);
  endtask

  task automatic do_clr();
    @(posedge clk); #1 bus.clr_i = 1'b1;
    @(posedge clk); #1 bus.clr_i = 1'b0;
    m_flags = 4'b0; m_pkt = 32'd0; m_errc = 0;
  endtask

  task automatic reset_dut();
    @(posedge clk); #1;
    srst = 1'b1;
    bus.snk_valid_i = 1'b0;
    bus.clr_i = 1'b0;
    bus.src_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_snk_ready", bus.snk_ready_o, 0);
    check("rst_src_valid", bus.src_valid_o, 0);
    check("rst_src_data", bus.src_data_o, 0);
    check("rst_sop_eop", {bus.src_startofpacket_o, bus.src_endofpacket_o}, 0);
    check("rst_done_err", {bus.pkt_done_o, bus.pkt_err_o}, 0);
    check("rst_flags", bus.err_flags_o, 0);
    check("rst_cnts", bus.pkt_cnt_o | 32'(bus.err_cnt_o), 0);
    @(posedge clk); #1 srst = 1'b0;
    m_reset();
    @(negedge clk);
    check("post_rst_ready", bus.snk_ready_o, 1);
  endtask

  initial begin
    logic [31:0] v;
    srst = 1'b1;
    bus.snk_valid_i = 1'b0;
    bus.snk_data_i = '0;
    bus.snk_startofpacket_i = 1'b0;
    bus.snk_endofpacket_i = 1'b0;
    bus.src_ready_i = 1'b1;
    bus.clr_i = 1'b0;
    m_reset();
    reset_dut();

    // Clean packet, then out-of-order packet.
    push(1, 1, 0); push(2, 0, 0); push(2, 0, 0); push(9, 0, 1);
    run(0, 0, -1); check_status("clean");
    push(5, 1, 0); push(3, 0, 0); push(7, 0, 1);
    run(0, 0, -1); check_status("order");

    // Orphan beat then single-beat packet.
    do_clr(); check_status("clr0");
    push(8, 0, 0); push(4, 1, 1);
    run(0, 0, -1); check_status("orphan");

    // Missing EOP then a good packet.
    do_clr();
    push(1, 1, 0); push(2, 0, 0); push(3, 1, 0); push(4, 0, 1);
    run(0, 0, -1); check_status("dup_sop");

    // Over-length by one, then exactly max length.
    do_clr();
    for (int i = 0; i <= MAXL; i++) push(i, i == 0, i == MAXL);
    for (int i = 0; i < MAXL; i++) push(i, i == 0, i == MAXL - 1);
    run(0, 0, -1); check_status("length");

    // Dup SOP that is also EOP, followed immediately by another 1-beat packet.
    do_clr();
    push(10, 1, 0); push(11, 0, 0); push(12, 1, 1); push(13, 1, 1);
    run(0, 0, -1); check_status("dup_sop_eop");

    // Reset in the middle of a packet.
    push(1, 1, 0); push(2, 0, 0);
    run(0, 0, -1);
    reset_dut();
    push(7, 0, 0); push(8, 1, 1);
    run(0, 0, -1); check_status("mid_rst");

    // 50-beat sorted packet with random valid/ready.
    do_clr();
    v = $urandom_range(0, 100);
    for (int i = 0; i < 50; i++) begin
      push(v, i == 0, i == 49);
      v = v + $urandom_range(0, 3);
    end
    run(1, 1, -1); check_status("bp50");

    // clr colliding with an errored close, then with a clean close.
    push(3, 1, 0); push(1, 0, 0); push(9, 0, 1);
    push(6, 1, 0); push(2, 0, 1);
    run(0, 0, 4); check_status("clr_err_close");
    push(1, 1, 0); push(2, 0, 0); push(3, 0, 1);
    run(0, 0, 2); check_status("clr_ok_close");

    // Random framing and ordering.
    for (int i = 0; i < 300; i++)
      push($urandom_range(0, 20), $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0);
    run(1, 1, -1); check_status("rand1");
    do_clr(); check_status("rand_clr");
    for (int i = 0; i < 200; i++)
      push($urandom_range(0, 20), $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0);
    run(1, 1, -1); check_status("rand2");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
